// File: rtl/mem_rr_sched.sv
// mem_rr_sched: round-robin arbiter sharing one fixed-latency main-memory port between
// the icache and dcache miss paths, steering responses back and flagging protocol errors.
module mem_rr_sched #(
   parameter int ADDR_W        = 26,
   parameter int DATA_W        = 512,
   parameter int MEM_LATENCY   = 4,
   parameter int TIMEOUT_SLACK = 4
) (
   input  logic              clk,
   input  logic              rst_aL,
   input  logic              icache_req_valid,
   input  logic [ADDR_W-1:0] icache_req_block_addr,
   output logic              icache_req_ready,
   output logic              icache_resp_valid,
   output logic [DATA_W-1:0] icache_resp_block_data,
   input  logic              dcache_req_valid,
   input  logic              dcache_req_type,
   input  logic [ADDR_W-1:0] dcache_req_block_addr,
   input  logic [DATA_W-1:0] dcache_req_block_data,
   output logic              dcache_req_ready,
   output logic              dcache_resp_valid,
   output logic [DATA_W-1:0] dcache_resp_block_data,
   output logic              mem_req_valid,
   output logic              mem_req_cache_type,
   output logic              mem_req_type,
   output logic [ADDR_W-1:0] mem_req_block_addr,
   output logic [DATA_W-1:0] mem_req_block_data,
   input  logic              mem_resp_valid,
   input  logic              mem_resp_cache_type,
   input  logic [DATA_W-1:0] mem_resp_block_data,
   output logic              err,
   output logic              busy
);
   localparam int LIMIT = MEM_LATENCY + TIMEOUT_SLACK;
   localparam int CW    = $clog2(LIMIT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_nx;
   logic last_grant, grant_d, accept, match, timeout;
   logic [CW-1:0] cnt;
   // the latched request fields double as the memory request outputs
   always_comb begin
      grant_d                = dcache_req_valid && (!icache_req_valid || !last_grant);
      icache_req_ready       = rst_aL && state == IDLE && !grant_d;
      dcache_req_ready       = rst_aL && state == IDLE && grant_d;
      accept                 = grant_d ? dcache_req_valid && dcache_req_ready
                                       : icache_req_valid && icache_req_ready;
      match                  = state == WAIT && mem_resp_valid && mem_resp_cache_type == mem_req_cache_type;
      timeout                = state == WAIT && !match && cnt == CW'(LIMIT);
      state_nx               = accept ? ISSUE : state == ISSUE ? WAIT : (match || timeout) ? IDLE : state;
      mem_req_valid          = state == ISSUE;
      busy                   = state != IDLE;
      icache_resp_valid      = match && !mem_req_cache_type;
      dcache_resp_valid      = match && mem_req_cache_type;
      icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
      dcache_resp_block_data = (dcache_resp_valid && !mem_req_type) ? mem_resp_block_data : '0;
   end
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state              <= IDLE;
         last_grant         <= 1'b1;
         cnt                <= '0;
         err                <= 1'b0;
         mem_req_cache_type <= 1'b0;
         mem_req_type       <= 1'b0;
         mem_req_block_addr <= '0;
         mem_req_block_data <= '0;
      end else begin
         state <= state_nx;
         err   <= err || (mem_resp_valid && !match) || timeout;
         cnt   <= accept ? '0 : (state != IDLE && cnt != CW'(LIMIT)) ? cnt + CW'(1) : cnt;
         if (accept) begin
            last_grant         <= grant_d;
            mem_req_cache_type <= grant_d;
            mem_req_type       <= grant_d && dcache_req_type;
            mem_req_block_addr <= grant_d ? dcache_req_block_addr : icache_req_block_addr;
            mem_req_block_data <= grant_d ? dcache_req_block_data : '0;
         end
      end
   end
endmodule
